uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter.
- Input side: valid/ready handshake into a small internal FIFO, so the source can queue words ahead of the line.
- Frame setup per frame: data length (5–8 bits), parity (none/even/odd), stop bits (1/2) and bit-period divisor.
- Consecutive frames are sent back-to-back.
- Sits between the system-side producer (CPU/DMA wrapper) and the serial TxD pin.

---
 rtl/uart_tx_cfg.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : Runtime-configurable UART transmitter. It has a valid/ready input
//            FIFO, 5..8 data bits, none/even/odd parity, 1 or 2 stop bits and
//            a per-bit clock divisor. Queued frames are sent back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_len,
    input  logic              cfg_par_en,
    input  logic              cfg_par_odd,
    input  logic              cfg_stop2,
    output logic              TxD,
    output logic              busy,
    output logic              tx_done,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int               c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_full    = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] c_div_one = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_head;

    assign w_full     = (r_count == c_full);
    assign w_empty    = (r_count == '0);
    assign tx_ready   = ~w_full;
    assign w_push     = tx_valid & ~w_full;
    assign w_head     = r_mem[r_rptr];
    assign fifo_count = r_count;

    // FIFO storage; contents need no reset because the count gates all reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame setup derived from the FIFO head and live configuration
    // ------------------------------------------------------------------
    logic [3:0]        w_len_bits;
    logic [DATA_W-1:0] w_mask;
    logic              w_par_calc;
    logic [DIV_W-1:0]  w_div_n;

    // Mask of the data bits that belong to the frame, and the resulting parity
    always_comb begin
        w_mask     = '0;
        w_len_bits = 4'd5 + {2'b00, cfg_len};
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (4'(i) < w_len_bits);
        end
        w_par_calc = (^(w_head & w_mask)) ^ cfg_par_odd;
        w_div_n    = (cfg_div == '0) ? c_div_one : cfg_div;
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_shift;
    logic [1:0]        r_len;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;
    logic [DIV_W-1:0]  r_div_n;
    logic [DIV_W-1:0]  r_cyc;
    logic [2:0]        r_bit;
    logic              r_stop_second;
    logic              r_txd;
    logic              r_done;

    logic w_bit_end;
    logic w_last_data;
    logic w_start;
    logic w_done;
    logic w_txd_next;
    logic w_shift;
    logic w_bit_inc;
    logic w_stop_set;

    // r_div_n is never zero, so the subtraction cannot wrap
    assign w_bit_end   = (r_cyc == (r_div_n - c_div_one));
    assign w_last_data = (r_bit == ({1'b0, r_len} + 3'd4));
    assign w_pop       = w_start;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-edge control strobes
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_txd_next   = r_txd;
        w_shift      = 1'b0;
        w_bit_inc    = 1'b0;
        w_stop_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_next = 1'b1;
                if (!w_empty) begin
                    w_start      = 1'b1;
                    w_next_state = S_START;
                    w_txd_next   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                    w_txd_next   = r_shift[0];
                    w_shift      = 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (w_last_data) begin
                        if (r_par_en) begin
                            w_next_state = S_PARITY;
                            w_txd_next   = r_par_bit;
                        end else begin
                            w_next_state = S_STOP;
                            w_txd_next   = 1'b1;
                        end
                    end else begin
                        w_txd_next = r_shift[0];
                        w_shift    = 1'b1;
                        w_bit_inc  = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                    w_txd_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && !r_stop_second) begin
                        w_stop_set = 1'b1;
                    end else begin
                        w_done = 1'b1;
                        if (!w_empty) begin
                            // Chain straight into the next frame with no idle bit
                            w_start      = 1'b1;
                            w_next_state = S_START;
                            w_txd_next   = 1'b0;
                        end else begin
                            w_next_state = S_IDLE;
                            w_txd_next   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    // Frame latch, bit timing counters and registered line/done outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_txd         <= 1'b1;
            r_done        <= 1'b0;
            r_cyc         <= '0;
            r_bit         <= '0;
            r_stop_second <= 1'b0;
            r_shift       <= '0;
            r_len         <= '0;
            r_par_en      <= 1'b0;
            r_par_bit     <= 1'b0;
            r_stop2       <= 1'b0;
            r_div_n       <= c_div_one;
        end else begin
            r_txd  <= w_txd_next;
            r_done <= w_done;
            if (w_start) begin
                r_shift       <= w_head;
                r_len         <= cfg_len;
                r_par_en      <= cfg_par_en;
                r_par_bit     <= w_par_calc;
                r_stop2       <= cfg_stop2;
                r_div_n       <= w_div_n;
                r_cyc         <= '0;
                r_bit         <= '0;
                r_stop_second <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_cyc <= w_bit_end ? '0 : (r_cyc + c_div_one);
                if (w_shift) begin
                    r_shift <= r_shift >> 1;
                end
                if (w_bit_inc) begin
                    r_bit <= r_bit + 3'd1;
                end
                if (w_stop_set) begin
                    r_stop_second <= 1'b1;
                end
            end
        end
    end

    assign TxD     = r_txd;
    assign busy    = (r_state != S_IDLE);
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : Directed self-checking bench for uart_tx_cfg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_len;
    logic        cfg_par_en;
    logic        cfg_par_odd;
    logic        cfg_stop2;
    logic        TxD;
    logic        busy;
    logic        tx_done;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    // process-private variables for the concurrent part of the run
    logic [31:0] smp_bits;
    logic        smp_held;
    int          smp_wait;
    logic        drv_acc;
    int          drv_tries;
    int          mon_low;
    int          mon_busy;
    logic [31:0] t4_exp [6];

    always #5 clk = ~clk;

    uart_tx_cfg dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .cfg_div     (cfg_div),
        .cfg_len     (cfg_len),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .TxD         (TxD),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [1:0] len,
                           input logic pe, input logic po, input logic s2);
        cfg_div     = div;
        cfg_len     = len;
        cfg_par_en  = pe;
        cfg_par_odd = po;
        cfg_stop2   = s2;
    endtask

    // Called at the negedge of the first start-bit cycle; records the line level
    // at the start of each bit and whether it stayed put for all n cycles.
    task automatic sample_frame(input int nbits, input int n,
                                output logic [31:0] bits, output logic held);
        bits = '0;
        held = 1'b1;
        for (int i = 0; i < nbits * n; i++) begin
            if (i > 0) @(negedge clk);
            if (i % n == 0) bits[i / n] = TxD;
            else if (TxD !== bits[i / n]) held = 1'b0;
        end
    endtask

    // Push one word into an idle block and check the whole frame around it
    task automatic send_one(input string tag, input logic [7:0] d, input int nbits,
                            input int n, input logic [31:0] exp_bits);
        logic [31:0] bits;
        logic        held;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        check({tag, "_pre_txd"}, 32'(TxD), 32'h1);
        check({tag, "_pre_cnt"}, 32'(fifo_count), 32'h1);
        @(negedge clk);
        check({tag, "_start"}, 32'(TxD), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h1);
        sample_frame(nbits, n, bits, held);
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_held"}, 32'(held), 32'h1);
        @(negedge clk);
        check({tag, "_done"}, 32'(tx_done), 32'h1);
        check({tag, "_idle"}, 32'(busy), 32'h0);
        check({tag, "_txd_hi"}, 32'(TxD), 32'h1);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(tx_done), 32'h0);
        check({tag, "_txd_stay"}, 32'(TxD), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t4_exp = '{32'h202, 32'h204, 32'h206, 32'h208, 32'h20A, 32'h20C};
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_txd", 32'(TxD), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(tx_done), 32'h0);
        check("rst_ready", 32'(tx_ready), 32'h1);
        check("rst_cnt", 32'(fifo_count), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // 8N1, divisor 4, alternating pattern
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        send_one("t1", 8'h55, 10, 4, 32'h2AA);

        // Divisor 0 behaves as 1
        set_cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0);
        send_one("t1z", 8'h55, 10, 1, 32'h2AA);

        // 7 data bits with even then odd parity
        set_cfg(16'd3, 2'b10, 1'b1, 1'b0, 1'b0);
        send_one("t2e", 8'h41, 10, 3, 32'h282);
        set_cfg(16'd3, 2'b10, 1'b1, 1'b1, 1'b0);
        send_one("t2o", 8'h41, 10, 3, 32'h382);

        // 5 data bits, two stop bits; upper data bits ignored
        set_cfg(16'd2, 2'b00, 1'b0, 1'b0, 1'b1);
        send_one("t3", 8'hFF, 8, 2, 32'hFE);

        // Six words offered back-to-back into a depth-4 FIFO
        set_cfg(16'd2, 2'b11, 1'b0, 1'b0, 1'b0);
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    tx_valid  = 1'b1;
                    tx_data   = 8'(k);
                    drv_acc   = 1'b0;
                    drv_tries = 0;
                    while (!drv_acc && drv_tries < 80) begin
                        drv_acc = tx_ready;
                        drv_tries++;
                        @(negedge clk);
                    end
                    check($sformatf("t4_accept%0d", k), 32'(drv_acc), 32'h1);
                    if (k <= 5) check($sformatf("t4_nostall%0d", k), 32'(drv_tries), 32'd1);
                    if (k == 5) begin
                        check("t4_ready_full", 32'(tx_ready), 32'h0);
                        check("t4_cnt_full", 32'(fifo_count), 32'd4);
                    end
                    if (k == 6) begin
                        check("t4_stalled6", 32'(drv_tries > 1), 32'h1);
                        check("t4_cnt_after6", 32'(fifo_count), 32'd4);
                    end
                end
                tx_valid = 1'b0;
            end
            begin
                smp_wait = 0;
                while (TxD !== 1'b0 && smp_wait < 50) begin
                    @(negedge clk);
                    smp_wait++;
                end
                check("t4_first_start", 32'(TxD), 32'h0);
                for (int f = 0; f < 6; f++) begin
                    sample_frame(10, 2, smp_bits, smp_held);
                    check($sformatf("t4_f%0d_bits", f), smp_bits, t4_exp[f]);
                    check($sformatf("t4_f%0d_held", f), 32'(smp_held), 32'h1);
                    @(negedge clk);
                    check($sformatf("t4_f%0d_done", f), 32'(tx_done), 32'h1);
                    if (f < 5) begin
                        check($sformatf("t4_f%0d_nogap", f), 32'(TxD), 32'h0);
                        check($sformatf("t4_f%0d_busy", f), 32'(busy), 32'h1);
                    end else begin
                        check("t4_end_idle", 32'(busy), 32'h0);
                        check("t4_end_txd", 32'(TxD), 32'h1);
                    end
                end
            end
        join
        @(negedge clk);

        // Configuration change in the middle of the first of two queued frames
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'h0F;
        @(negedge clk);
        tx_data  = 8'h2B;
        @(negedge clk);
        tx_valid = 1'b0;
        check("t5_start", 32'(TxD), 32'h0);
        set_cfg(16'd8, 2'b01, 1'b0, 1'b0, 1'b0);
        sample_frame(10, 4, smp_bits, smp_held);
        check("t5_f0_bits", smp_bits, 32'h21E);
        check("t5_f0_held", 32'(smp_held), 32'h1);
        @(negedge clk);
        check("t5_f0_done", 32'(tx_done), 32'h1);
        check("t5_nogap", 32'(TxD), 32'h0);
        sample_frame(8, 8, smp_bits, smp_held);
        check("t5_f1_bits", smp_bits, 32'hD6);
        check("t5_f1_held", 32'(smp_held), 32'h1);
        @(negedge clk);
        check("t5_f1_done", 32'(tx_done), 32'h1);
        check("t5_idle", 32'(busy), 32'h0);
        @(negedge clk);

        // Asynchronous reset during the data bits of the second of three frames
        set_cfg(16'd2, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge clk);
        tx_data  = 8'h00;
        @(negedge clk);
        tx_data  = 8'h33;
        @(negedge clk);
        tx_valid = 1'b0;
        smp_wait = 0;
        while (tx_done !== 1'b1 && smp_wait < 60) begin
            @(negedge clk);
            smp_wait++;
        end
        check("t6_first_done", 32'(tx_done), 32'h1);
        repeat (4) @(negedge clk);
        check("t6_in_data_txd", 32'(TxD), 32'h0);
        check("t6_in_data_busy", 32'(busy), 32'h1);
        check("t6_in_data_cnt", 32'(fifo_count), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_txd", 32'(TxD), 32'h1);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_cnt", 32'(fifo_count), 32'h0);
        check("t6_async_ready", 32'(tx_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        mon_low  = 0;
        mon_busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) mon_low++;
            if (busy !== 1'b0) mon_busy++;
        end
        check("t6_quiet_txd", 32'(mon_low), 32'd0);
        check("t6_quiet_busy", 32'(mon_busy), 32'd0);
        send_one("t6_new", 8'hA5, 10, 2, 32'h34A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
